// File: rtl/adc_meas_pkg.sv
// Shared types and constants for the ADC measurement/display path.
package adc_meas_pkg;

  localparam int unsigned ADC_W           = 12;
  localparam int unsigned BCD_W           = 16;
  localparam int unsigned CNT_W           = 11;
  localparam int unsigned ACC_W           = 16;
  localparam int unsigned WIN_LEN_DEFAULT = 2048;

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StScale,
    StConv,
    StDone
  } state_e;

  // Millivolts from an ADC code: (code * vref) >> 12, truncating.
  function automatic logic [ADC_W-1:0] scale_mv(input logic [ADC_W-1:0] code,
                                                input logic [ADC_W-1:0] vref);
    logic [2*ADC_W-1:0] prod;
    prod = {{ADC_W{1'b0}}, code} * {{ADC_W{1'b0}}, vref};
    return prod[2*ADC_W-1 -: ADC_W];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit packed BCD (double dabble).
// start_i loads bin_i; 12 shift cycles follow; done_o pulses for one cycle
// once bcd_o holds the result.
module bin2bcd_seq
  import adc_meas_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ADC_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o
);

  localparam int unsigned ShW    = BCD_W + ADC_W;
  localparam logic [3:0]  ItLast = 4'(ADC_W - 1);

  logic [ShW-1:0] sh_q, sh_d, adj;
  logic [3:0]     it_q, it_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  // Add-3 correction on every BCD nibble, then the next shift step.
  always_comb begin
    adj = sh_q;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (adj[ADC_W + 4*k +: 4] >= 4'd5) begin
        adj[ADC_W + 4*k +: 4] = adj[ADC_W + 4*k +: 4] + 4'd3;
      end
    end
    sh_d   = sh_q;
    it_d   = it_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      sh_d  = {{BCD_W{1'b0}}, bin_i};
      it_d  = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d = {adj[ShW-2:0], 1'b0};
      it_d = it_q + 4'd1;
      if (it_q == ItLast) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Shift register and iteration state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      it_q   <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      it_q   <= it_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign bcd_o  = sh_q[ShW-1 -: BCD_W];
  assign done_o = done_q;

endmodule

// File: rtl/vpp_display_conv.sv
// Peak-to-peak display converter: Vpp = max - min per upstream window,
// optional 2^AVG_LOG2 averaging, scaling to mV and conversion to packed BCD.
module vpp_display_conv
  import adc_meas_pkg::*;
#(
  parameter int unsigned WIN_LEN  = WIN_LEN_DEFAULT,
  parameter int unsigned AVG_LOG2 = 0,
  parameter int unsigned VREF_MV  = 3300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] max_i,
  input  logic [ADC_W-1:0] min_i,
  output logic [ADC_W-1:0] vpp_raw_o,
  output logic [ADC_W-1:0] vpp_mv_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             out_valid_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIN_LEN - 1);
  localparam logic [3:0]       NLast   = 4'((1 << AVG_LOG2) - 1);
  localparam logic [ADC_W-1:0] VrefMv  = ADC_W'(VREF_MV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             cap_q, cap_d;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [3:0]       n_q, n_d;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic [ADC_W-1:0] mv_q, mv_d, mv_calc;
  logic [ADC_W-1:0] vpp_raw_q, vpp_raw_d;
  logic [ADC_W-1:0] vpp_mv_q, vpp_mv_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, conv_bcd;
  logic             conv_start, conv_done;

  // Window counter; cap_q is high in the cycle after a wrap edge, i.e. while
  // cnt==0 and upstream holds the freshly loaded max/min. The first wrap
  // after reset only arms seen_q, so that window is skipped.
  always_comb begin
    cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    seen_d = seen_q | (cnt_q == CntLast);
    cap_d  = (cnt_q == CntLast) && seen_q;
  end

  // Window counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      cap_q  <= cap_d;
    end
  end

  assign mv_calc = scale_mv(avg_q, VrefMv);

  // Next-state and datapath for capture, accumulate, scale and convert.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    n_d        = n_q;
    avg_d      = avg_q;
    mv_d       = mv_q;
    vpp_raw_d  = vpp_raw_q;
    vpp_mv_d   = vpp_mv_q;
    bcd_d      = bcd_q;
    conv_start = 1'b0;
    sum        = acc_q + ACC_W'(vpp_raw_q);
    unique case (state_q)
      StIdle: begin
        // Captures arriving outside idle are dropped.
        if (cap_q) begin
          vpp_raw_d = (max_i >= min_i) ? (max_i - min_i) : '0;
          state_d   = StAcc;
        end
      end
      StAcc: begin
        if (n_q == NLast) begin
          avg_d   = ADC_W'(sum >> AVG_LOG2);
          acc_d   = '0;
          n_d     = '0;
          state_d = StScale;
        end else begin
          acc_d   = sum;
          n_d     = n_q + 4'd1;
          state_d = StIdle;
        end
      end
      StScale: begin
        mv_d       = mv_calc;
        conv_start = 1'b1;
        state_d    = StConv;
      end
      StConv: begin
        // Results land on the edge into DONE so they are valid with the pulse.
        if (conv_done) begin
          vpp_mv_d = mv_q;
          bcd_d    = conv_bcd;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      n_q       <= '0;
      avg_q     <= '0;
      mv_q      <= '0;
      vpp_raw_q <= '0;
      vpp_mv_q  <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      n_q       <= n_d;
      avg_q     <= avg_d;
      mv_q      <= mv_d;
      vpp_raw_q <= vpp_raw_d;
      vpp_mv_q  <= vpp_mv_d;
      bcd_q     <= bcd_d;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (mv_calc),
    .bcd_o   (conv_bcd),
    .done_o  (conv_done)
  );

  assign vpp_raw_o   = vpp_raw_q;
  assign vpp_mv_o    = vpp_mv_q;
  assign bcd_o       = bcd_q;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);

endmodule
